// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Multi-cycle program-counter sequencer. Owns the architectural PC, issues
//   instruction-memory fetches, holds the fetched instruction for the
//   datapath, and computes the next PC (sequential or PC-relative branch)
//   once the datapath reports the instruction complete.
//
// Handshakes:
//   imem_req is high for every FETCH cycle; the sequencer stays in FETCH
//   until imem_ack is seen high on a rising edge, at which point imem_rdata
//   is captured. instr_valid is high for every EXEC cycle; the sequencer
//   stays in EXEC until exec_done is seen high on a rising edge, at which
//   point branch/imm16/halt are sampled. Strobes seen in any other state
//   are ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  fetch request and address (address always equals pc)
//   imem_ack/imem_rdata fetch completion and returned instruction word
//   instr/instr_valid   latched instruction, valid while in EXEC
//   exec_done, branch,  datapath completion and next-PC controls
//   imm16, halt
//   pc, retired         current PC and retired-instruction count
//   halted, fault       halted state flag, sticky misaligned-branch flag
//   dbg_state           current FSM state encoding

module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch,
    input  logic [15:0] imm16,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic        r_fault;

    logic [31:0] w_seq;
    logic [31:0] w_tgt;
    logic [31:0] w_next;

    // Branch offset is a byte offset relative to pc+4, not shifted.
    assign w_seq  = r_pc + 32'd4;
    assign w_tgt  = w_seq + {{16{imm16[15]}}, imm16};
    assign w_next = branch ? w_tgt : w_seq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_retired <= 32'd0;
            r_fault   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        if (halt) begin
                            // Halt wins over a misaligned target.
                            r_retired <= r_retired + 32'd1;
                            r_state   <= S_HALTED;
                        end else if (w_next[1:0] != 2'b00) begin
                            // Faulting instruction does not retire.
                            r_fault <= 1'b1;
                            r_state <= S_HALTED;
                        end else begin
                            r_pc      <= w_next;
                            r_retired <= r_retired + 32'd1;
                            r_state   <= S_FETCH;
                        end
                    end
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; the async reset forces the
    // strobes low the moment rst_n falls.
    assign imem_req    = (r_state == S_FETCH);
    assign instr_valid = (r_state == S_EXEC);
    assign halted      = (r_state == S_HALTED);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign retired     = r_retired;
    assign fault       = r_fault;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed bench for pc_sequencer. Inputs are driven on the falling edge
//   and outputs are checked on the falling edge, half a cycle away from the
//   active rising edge. A second instance with RESET_PC = 32'hFFFF_FFFC is
//   held in reset except while the wrap-around scenario runs.

module tb_pc_sequencer;

    localparam logic [31:0] RST_PC  = 32'h0040_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst_n;
    logic        rst2_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        exec_done;
    logic        branch;
    logic [15:0] imm16;
    logic        halt;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        halted;
    logic        fault;
    logic [1:0]  dbg_state;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_retired;
    logic        w_halted;
    logic        w_fault;
    logic [1:0]  w_dbg_state;

    int checks;
    int errors;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .branch(branch), .imm16(imm16), .halt(halt),
        .pc(pc), .retired(retired), .halted(halted), .fault(fault),
        .dbg_state(dbg_state)
    );

    pc_sequencer #(.RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .rst_n(rst2_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(w_instr), .instr_valid(w_valid),
        .exec_done(exec_done), .branch(branch), .imm16(imm16), .halt(halt),
        .pc(w_pc), .retired(w_retired), .halted(w_halted), .fault(w_fault),
        .dbg_state(w_dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        exec_done  = 1'b0;
        branch     = 1'b0;
        imm16      = 16'd0;
        halt       = 1'b0;
    endtask

    // Reset the main instance, check the reset state, release on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if (pc !== RST_PC || retired !== 32'd0 || instr !== 32'd0 || fault !== 1'b0 ||
            imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: pc=%h ret=%0d instr=%h flt=%b req=%b val=%b hlt=%b st=%0d required pc=%h ret=0 instr=0 all strobes 0 st=0",
                     pc, retired, instr, fault, imem_req, instr_valid, halted, dbg_state, RST_PC);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL req_during_idle: got %b required 0", imem_req);
        end
    endtask

    // Wait (bounded) for a fetch request, ending on a falling edge.
    task automatic wait_req();
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout: imem_req=%b after %0d cycles, required 1", imem_req, n);
        end
    endtask

    task automatic give_ack(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
    endtask

    task automatic give_done(input logic b, input logic [15:0] imm, input logic h);
        exec_done = 1'b1;
        branch    = b;
        imm16     = imm;
        halt      = h;
        @(negedge clk);
        clear_inputs();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset_straight();
        logic [31:0] word;
        do_reset();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL first_req_latency: got %b required 1", imem_req);
        end
        for (int k = 0; k < 3; k++) begin
            word = 32'hA000_0000 + k;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'(4 * k)) begin
                errors++;
                $display("FAIL seq_addr_%0d: req=%b addr=%h required req=1 addr=%h",
                         k, imem_req, imem_addr, RST_PC + 32'(4 * k));
            end
            give_ack(word);
            checks++;
            if (instr_valid !== 1'b1 || instr !== word || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL seq_exec_%0d: valid=%b instr=%h req=%b required valid=1 instr=%h req=0",
                         k, instr_valid, instr, imem_req, word);
            end
            give_done(1'b0, 16'd0, 1'b0);
        end
        checks++;
        if (retired !== 32'd3 || pc !== 32'h0040_000C) begin
            errors++;
            $display("FAIL straight_end: retired=%0d pc=%h required 3 / 0040000c", retired, pc);
        end
    endtask

    task automatic test_branch();
        wait_req();
        give_ack(32'hB000_0001);
        give_done(1'b0, 16'd0, 1'b0);
        checks++;
        if (pc !== 32'h0040_0010) begin
            errors++;
            $display("FAIL pre_branch_pc: got %h required 00400010", pc);
        end
        wait_req();
        give_ack(32'hB000_0002);
        give_done(1'b1, 16'h0010, 1'b0);
        checks++;
        if (pc !== 32'h0040_0024 || imem_addr !== 32'h0040_0024) begin
            errors++;
            $display("FAIL branch_fwd: pc=%h addr=%h required 00400024", pc, imem_addr);
        end
        wait_req();
        give_ack(32'hB000_0003);
        give_done(1'b1, 16'hFFF0, 1'b0);
        checks++;
        if (pc !== 32'h0040_0018 || retired !== 32'd6) begin
            errors++;
            $display("FAIL branch_back: pc=%h retired=%0d required 00400018 / 6", pc, retired);
        end
    endtask

    task automatic test_wait_stray();
        wait_req();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || pc !== 32'h0040_0018 || retired !== 32'd6) begin
                errors++;
                $display("FAIL fetch_wait_%0d: req=%b pc=%h retired=%0d required 1 / 00400018 / 6",
                         i, imem_req, pc, retired);
            end
            if (i == 0) begin
                // Stray exec_done while fetching must be ignored.
                give_done(1'b1, 16'h0100, 1'b0);
            end else if (i < 3) begin
                @(negedge clk);
            end else begin
                give_ack(32'hC0DE_0001);
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || pc !== 32'h0040_0018 || retired !== 32'd6 ||
                instr !== 32'hC0DE_0001) begin
                errors++;
                $display("FAIL exec_wait_%0d: valid=%b pc=%h retired=%0d instr=%h required 1 / 00400018 / 6 / c0de0001",
                         i, instr_valid, pc, retired, instr);
            end
            // Stray ack while executing must not recapture the instruction.
            give_ack(32'hDEAD_BEEF);
        end
        give_done(1'b0, 16'd0, 1'b0);
        checks++;
        if (pc !== 32'h0040_001C || retired !== 32'd7 || instr !== 32'hC0DE_0001) begin
            errors++;
            $display("FAIL after_wait: pc=%h retired=%0d instr=%h required 0040001c / 7 / c0de0001",
                     pc, retired, instr);
        end
    endtask

    task automatic test_halt();
        wait_req();
        give_ack(32'hD000_0001);
        // Halt together with a misaligned target: halt wins.
        give_done(1'b1, 16'h0002, 1'b1);
        checks++;
        if (halted !== 1'b1 || fault !== 1'b0 || pc !== 32'h0040_001C || retired !== 32'd8 ||
            imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_state: hlt=%b flt=%b pc=%h ret=%0d req=%b val=%b required 1 0 0040001c 8 0 0",
                     halted, fault, pc, retired, imem_req, instr_valid);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        exec_done  = 1'b1;
        repeat (3) @(negedge clk);
        clear_inputs();
        checks++;
        if (halted !== 1'b1 || pc !== 32'h0040_001C || retired !== 32'd8 ||
            instr !== 32'hD000_0001 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_frozen: hlt=%b pc=%h ret=%0d instr=%h req=%b required 1 0040001c 8 d0000001 0",
                     halted, pc, retired, instr, imem_req);
        end
    endtask

    task automatic test_fault();
        do_reset();
        wait_req();
        give_ack(32'hE000_0001);
        give_done(1'b1, 16'h0002, 1'b0);
        checks++;
        if (fault !== 1'b1 || halted !== 1'b1 || pc !== RST_PC || retired !== 32'd0) begin
            errors++;
            $display("FAIL fault_state: flt=%b hlt=%b pc=%h ret=%0d required 1 1 %h 0",
                     fault, halted, pc, retired, RST_PC);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (fault !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL fault_sticky: flt=%b req=%b required 1 0", fault, imem_req);
        end
    endtask

    task automatic test_wrap();
        rst2_n = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        checks++;
        if (w_req !== 1'b1 || w_addr !== WRAP_PC) begin
            errors++;
            $display("FAIL wrap_first_fetch: req=%b addr=%h required 1 fffffffc", w_req, w_addr);
        end
        give_ack(32'hF000_0001);
        give_done(1'b0, 16'd0, 1'b0);
        checks++;
        if (w_pc !== 32'h0000_0000 || w_retired !== 32'd1 || w_req !== 1'b1) begin
            errors++;
            $display("FAIL wrap_seq: pc=%h ret=%0d req=%b required 00000000 1 1", w_pc, w_retired, w_req);
        end
        give_ack(32'hF000_0002);
        give_done(1'b1, 16'hFFF0, 1'b0);
        checks++;
        if (w_pc !== 32'hFFFF_FFF4 || w_fault !== 1'b0) begin
            errors++;
            $display("FAIL wrap_neg_branch: pc=%h flt=%b required fffffff4 0", w_pc, w_fault);
        end
        rst2_n = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        wait_req();
        give_ack(32'h5000_0001);
        give_done(1'b0, 16'd0, 1'b0);
        checks++;
        if (imem_req !== 1'b1 || pc !== 32'h0040_0004 || retired !== 32'd1) begin
            errors++;
            $display("FAIL pre_mid_reset: req=%b pc=%h ret=%0d required 1 00400004 1", imem_req, pc, retired);
        end
        // Assert reset between clock edges while fetching.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== RST_PC || retired !== 32'd0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_async: req=%b pc=%h ret=%0d st=%0d required 0 %h 0 0",
                     imem_req, pc, retired, dbg_state, RST_PC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: req=%b required 0", imem_req);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL mid_reset_restart: req=%b addr=%h required 1 %h", imem_req, imem_addr, RST_PC);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        clear_inputs();
        test_reset_straight();
        test_branch();
        test_wait_stray();
        test_halt();
        test_fault();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound in case a scenario stalls outside a bounded wait.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter sequencer for the CE361 processor: owns the architectural PC register, drives instruction-memory fetch requests, presents the fetched instruction to the datapath, and computes the next PC (sequential or PC-relative branch) once the datapath reports the instruction complete. It wraps the next-PC arithmetic in a state machine with a memory handshake, a halt path, a misaligned-branch fault, and a retired-instruction counter.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request, high only in FETCH.
- imem_addr  output  32  fetch address, always equal to pc.
- imem_ack  input  1  memory returns imem_rdata valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  latched instruction, stable through EXEC.
- instr_valid  output  1  high only in EXEC.
- exec_done  input  1  datapath finished current instruction.
- branch  input  1  nPC_sel: 1 selects branch target, sampled with exec_done.
- imm16  input  16  branch offset, sampled with exec_done.
- halt  input  1  stop after current instruction, sampled with exec_done.
- pc  output  32  current PC.
- retired  output  32  count of instructions retired.
- halted  output  1  high in HALTED.
- fault  output  1  sticky misaligned-branch flag.

## Operation
- States: IDLE, FETCH, EXEC, HALTED (2-bit encoding, implementer's choice).
- IDLE: entered on reset; unconditionally -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, -> EXEC. Otherwise stay (no timeout).
- EXEC: instr_valid=1. On exec_done:
  - halt=1: pc unchanged, retired+1, -> HALTED.
  - else compute next: seq = pc + 4; tgt = seq + sign-extend(imm16) (offset is a byte offset, not shifted; matches the team's existing next-PC convention); next = branch ? tgt : seq.
  - next[1:0] != 0: fault<=1, pc unchanged, retired unchanged, -> HALTED.
  - else pc<=next, retired+1, -> FETCH.
- HALTED: all strobes low, pc/instr/retired frozen; exits only via rst_n.
- Arithmetic modulo 2^32: pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000; negative imm16 wraps below 0 identically; no overflow flag.
- retired wraps 32'hFFFF_FFFF -> 0.
- Inputs outside their state ignored: imem_ack outside FETCH, exec_done/branch/imm16/halt outside EXEC.
- halt and misalignment simultaneous: halt wins (no target computed, fault stays 0).

## Timing
- Reset (async assert, any state, mid-fetch included): pc=RESET_PC, instr=0, retired=0, fault=0, state=IDLE; imem_req=0, instr_valid=0, halted=0 immediately on assertion. Deassertion synchronous to clk by the system.
- First imem_req one cycle after the first rising edge with rst_n high (IDLE occupies one cycle).
- imem_ack in the first FETCH cycle: EXEC next cycle; minimum fetch latency 1 cycle.
- exec_done in the first EXEC cycle: FETCH next cycle with new pc; minimum 2 cycles/instruction plus memory wait.
- pc, imem_addr, instr, retired change only on clock edges that leave EXEC (or FETCH for instr); all outputs registered or decoded from registered state only, no input-to-output combinational path.
- halted and fault visible the cycle after the terminating exec_done edge.

## Test plan
- Reset/straight-line: release rst_n, ack every fetch in 1 cycle, exec_done each EXEC with branch=0 -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008; retired=3 after third exec_done; first imem_req exactly 1 cycle after reset release.
- Branch forward/back: pc=0x00400010, branch=1, imm16=16'h0010 -> next pc 0x00400024; then imm16=16'hFFF0 -> 0x00400018.
- Wait states and stray strobes: hold imem_ack low 3 cycles, pulse exec_done during FETCH -> imem_req held 4 cycles, pc unchanged, retired unchanged until real EXEC completion.
- Halt and fault: exec_done with halt=1 -> halted=1, fault=0, pc frozen, retired+1, further acks ignored; separate run with branch=1, imm16=16'h0002 -> fault=1, halted=1, pc unchanged, retired unchanged; halt=1 with imm16=16'h0002 -> fault=0.
- Wrap-around: RESET_PC=32'hFFFF_FFFC, sequential step -> pc=0x00000000.
- Reset mid-operation: assert rst_n low between clock edges during FETCH with imem_req=1 -> imem_req drops immediately, pc=RESET_PC, retired=0, restart via IDLE.
